// File: rtl/prbs_pkg.sv
// rtl/prbs_pkg.sv - shared state encoding and default constants for the PRBS checker
package prbs_pkg;

  typedef enum logic [1:0] {
    FILL   = 2'd0,
    HUNT   = 2'd1,
    LOCKED = 2'd2
  } prbs_state_e;

  localparam logic [6:0] PRBS7_POLY = 7'h60;
  localparam logic [3:0] PRBS4_POLY = 4'h9;

  localparam int DEF_LOCK_CNT    = 16;
  localparam int DEF_WINDOW      = 64;
  localparam int DEF_LOSS_THRESH = 8;

endpackage

// File: rtl/prbs_lfsr_core.sv
// rtl/prbs_lfsr_core.sv - Fibonacci LFSR register with tap prediction and selectable load bit
module prbs_lfsr_core
  import prbs_pkg::*;
#(
  parameter int               WIDTH = 7,
  parameter logic [WIDTH-1:0] POLY  = PRBS7_POLY
) (
  input  logic clk,
  input  logic rst_n,
  input  logic i_en,
  input  logic i_d,
  output logic o_p
);

  logic [WIDTH-1:0] r_lfsr;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_lfsr <= '0;
    end else if (i_en) begin
      r_lfsr <= {r_lfsr[WIDTH-2:0], i_d};
    end
  end

  assign o_p = ^(r_lfsr & POLY);

endmodule

// File: rtl/prbs_lfsr_checker.sv
// rtl/prbs_lfsr_checker.sv - self-synchronising PRBS lock/BER monitor
// Optional PRBS_CHK_INV_EN adds rx_inv to invert rx_bit for polarity-swapped links.
module prbs_lfsr_checker
  import prbs_pkg::*;
#(
  parameter int               WIDTH       = 7,
  parameter logic [WIDTH-1:0] POLY        = PRBS7_POLY,
  parameter int               LOCK_CNT    = DEF_LOCK_CNT,
  parameter int               WINDOW      = DEF_WINDOW,
  parameter int               LOSS_THRESH = DEF_LOSS_THRESH,
  parameter int               ERR_W       = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             bit_vld,
  input  logic             rx_bit,
`ifdef PRBS_CHK_INV_EN
  input  logic             rx_inv,
`endif
  input  logic             clr_cnt,
  output logic             locked,
  output logic             err_pulse,
  output logic [ERR_W-1:0] err_cnt,
  output logic [1:0]       state
);

  localparam int FW = $clog2(WIDTH) + 1;
  localparam int MW = $clog2(LOCK_CNT) + 1;
  localparam int WW = $clog2(WINDOW) + 1;
  localparam int EW = $clog2(LOSS_THRESH) + 1;

  localparam logic [FW-1:0] FILL_LAST  = FW'(WIDTH - 1);
  localparam logic [MW-1:0] MATCH_LAST = MW'(LOCK_CNT - 1);
  localparam logic [WW-1:0] WIN_LAST   = WW'(WINDOW - 1);
  localparam logic [EW-1:0] LOSS_LAST  = EW'(LOSS_THRESH - 1);

  prbs_state_e      r_state;
  logic [FW-1:0]    r_fill;
  logic [MW-1:0]    r_match;
  logic [WW-1:0]    r_win;
  logic [EW-1:0]    r_werr;
  logic             r_locked;
  logic             r_err_pulse;
  logic [ERR_W-1:0] r_err_cnt;

  logic w_rx;
  logic w_p;
  logic w_d;
  logic w_mis;

`ifdef PRBS_CHK_INV_EN
  assign w_rx = rx_bit ^ rx_inv;
`else
  assign w_rx = rx_bit;
`endif

  // Once locked the register free-runs on its own prediction, so line errors never corrupt it.
  assign w_d   = (r_state == LOCKED) ? w_p : w_rx;
  assign w_mis = w_rx ^ w_p;

  prbs_lfsr_core #(
    .WIDTH (WIDTH),
    .POLY  (POLY)
  ) u_core (
    .clk   (clk),
    .rst_n (rst_n),
    .i_en  (bit_vld),
    .i_d   (w_d),
    .o_p   (w_p)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state     <= FILL;
      r_fill      <= '0;
      r_match     <= '0;
      r_win       <= '0;
      r_werr      <= '0;
      r_locked    <= 1'b0;
      r_err_pulse <= 1'b0;
      r_err_cnt   <= '0;
    end else begin
      r_err_pulse <= 1'b0;
      if (bit_vld) begin
        unique case (r_state)
          FILL: begin
            if (r_fill == FILL_LAST) begin
              r_state <= HUNT;
              r_fill  <= '0;
              r_match <= '0;
            end else begin
              r_fill <= r_fill + 1'b1;
            end
          end
          HUNT: begin
            if (w_mis) begin
              r_match <= '0;
            end else if (r_match == MATCH_LAST) begin
              r_state  <= LOCKED;
              r_locked <= 1'b1;
              r_win    <= '0;
              r_werr   <= '0;
            end else begin
              r_match <= r_match + 1'b1;
            end
          end
          LOCKED: begin
            if (w_mis) begin
              r_err_pulse <= 1'b1;
              if (r_err_cnt != '1) begin
                r_err_cnt <= r_err_cnt + 1'b1;
              end
            end
            // Loss of lock outranks the window rollover on the same bit.
            if (w_mis && (r_werr == LOSS_LAST)) begin
              r_state  <= FILL;
              r_locked <= 1'b0;
              r_fill   <= '0;
            end else if (r_win == WIN_LAST) begin
              r_win  <= '0;
              r_werr <= '0;
            end else begin
              r_win <= r_win + 1'b1;
              if (w_mis) begin
                r_werr <= r_werr + 1'b1;
              end
            end
          end
          default: r_state <= FILL;
        endcase
      end
      if (clr_cnt) begin
        r_err_cnt <= '0;
      end
    end
  end

  assign locked    = r_locked;
  assign err_pulse = r_err_pulse;
  assign err_cnt   = r_err_cnt;
  assign state     = r_state;

endmodule

// File: tb/tb_prbs_lfsr_checker.sv
// tb/tb_prbs_lfsr_checker.sv - directed bench with a bit-history model for prbs_lfsr_checker
module tb_prbs_lfsr_checker;

  localparam int W      = 7;
  localparam int LOCKN  = 16;
  localparam int WIN    = 64;
  localparam int LOSS   = 8;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        bit_vld = 1'b0;
  logic        rx_bit = 1'b0;
  logic        clr_cnt = 1'b0;
  logic        locked, err_pulse;
  logic [15:0] err_cnt;
  logic [1:0]  state;
  logic        s_locked, s_err_pulse;
  logic [3:0]  s_err_cnt;
  logic [1:0]  s_state;

  int total = 0;
  int bad = 0;
  bit cmp_en = 1'b0;

  always #5 clk = ~clk;

  prbs_lfsr_checker u_dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .bit_vld   (bit_vld),
    .rx_bit    (rx_bit),
`ifdef PRBS_CHK_INV_EN
    .rx_inv    (1'b0),
`endif
    .clr_cnt   (clr_cnt),
    .locked    (locked),
    .err_pulse (err_pulse),
    .err_cnt   (err_cnt),
    .state     (state)
  );

  prbs_lfsr_checker #(.ERR_W(4)) u_sat (
    .clk       (clk),
    .rst_n     (rst_n),
    .bit_vld   (bit_vld),
    .rx_bit    (rx_bit),
`ifdef PRBS_CHK_INV_EN
    .rx_inv    (1'b0),
`endif
    .clr_cnt   (clr_cnt),
    .locked    (s_locked),
    .err_pulse (s_err_pulse),
    .err_cnt   (s_err_cnt),
    .state     (s_state)
  );

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  // Model: phase plus plain counts over a history of shifted-in bits (newest first).
  bit [6:0] poly_v = 7'h60;
  int       m_phase, m_fill, m_match, m_win, m_werr;
  longint   m_err;
  bit       m_pulse;
  bit       m_hist[$];

  function automatic bit m_pred();
    bit p = 1'b0;
    for (int i = 0; i < W; i++)
      if (poly_v[i] && i < m_hist.size()) p ^= m_hist[i];
    return p;
  endfunction

  task automatic model_reset();
    m_phase = 0; m_fill = 0; m_match = 0; m_win = 0; m_werr = 0;
    m_err = 0; m_pulse = 1'b0;
    m_hist.delete();
  endtask

  task automatic model_update(input bit vld, input bit b, input bit clr);
    bit p, d;
    m_pulse = 1'b0;
    if (vld) begin
      p = m_pred();
      d = b;
      case (m_phase)
        0: begin
          m_fill++;
          if (m_fill == W) begin m_phase = 1; m_fill = 0; m_match = 0; end
        end
        1: begin
          if (b == p) begin
            m_match++;
            if (m_match == LOCKN) begin m_phase = 2; m_win = 0; m_werr = 0; end
          end else m_match = 0;
        end
        default: begin
          d = p;
          if (b != p) begin m_pulse = 1'b1; m_err++; m_werr++; end
          if (m_werr == LOSS) begin
            m_phase = 0; m_fill = 0;
          end else begin
            m_win++;
            if (m_win == WIN) begin m_win = 0; m_werr = 0; end
          end
        end
      endcase
      m_hist.push_front(d);
      if (m_hist.size() > W) void'(m_hist.pop_back());
    end
    if (clr) m_err = 0;
  endtask

  always @(negedge clk) begin
    if (cmp_en) begin
      chk("locked", locked, (m_phase == 2));
      chk("err_pulse", err_pulse, m_pulse);
      chk("err_cnt", err_cnt, (m_err > 65535) ? 65535 : m_err);
      chk("state", state, m_phase);
      chk("sat_err_pulse", s_err_pulse, m_pulse);
      chk("sat_err_cnt", s_err_cnt, (m_err > 15) ? 15 : m_err);
    end
  end

  bit [6:0] g = 7'h7F;

  task automatic next_bit(output bit b);
    b = ^(g & poly_v);
    g = {g[5:0], b};
  endtask

  task automatic step(input bit vld, input bit b, input bit clr);
    bit_vld = vld; rx_bit = b; clr_cnt = clr;
    @(posedge clk);
    model_update(vld, b, clr);
    @(negedge clk);
  endtask

  task automatic send(input bit flip, input bit clr);
    bit b;
    next_bit(b);
    step(1'b1, b ^ flip, clr);
  endtask

  task automatic lock_clean(input string name);
    int n = 0;
    for (int k = 0; k < 100; k++) begin
      send(1'b0, 1'b0);
      n++;
      if (locked === 1'b1) break;
    end
    chk(name, n, 23);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    int pulses, vcnt;
    model_reset();
    repeat (3) @(negedge clk);
    chk("rst_locked", locked, 0);
    chk("rst_err_pulse", err_pulse, 0);
    chk("rst_err_cnt", err_cnt, 0);
    chk("rst_state", state, 0);
    rst_n = 1'b1;
    cmp_en = 1'b1;

    lock_clean("lock_bits");
    chk("lock_state", state, 2);
    for (int k = 0; k < 500; k++) send(1'b0, 1'b0);
    chk("clean_err_cnt", err_cnt, 0);

    send(1'b1, 1'b0);
    chk("single_pulse", err_pulse, 1);
    chk("single_cnt", err_cnt, 1);
    pulses = 0;
    for (int k = 0; k < 10; k++) begin
      send(1'b0, 1'b0);
      pulses += err_pulse;
    end
    chk("single_no_more", pulses, 0);
    chk("single_still_locked", locked, 1);
    send(1'b0, 1'b1);
    chk("clr_cnt", err_cnt, 0);

    for (int k = 0; k < 7; k++) send(1'b1, 1'b0);
    chk("win1_cnt", err_cnt, 7);
    for (int k = 0; k < 57; k++) send(1'b0, 1'b0);
    for (int k = 0; k < 7; k++) send(1'b1, 1'b0);
    for (int k = 0; k < 56; k++) send(1'b0, 1'b0);
    chk("win2_locked", locked, 1);
    chk("win2_cnt", err_cnt, 14);
    send(1'b0, 1'b1);

    for (int k = 0; k < 7; k++) send(1'b1, 1'b0);
    chk("loss_pre_locked", locked, 1);
    send(1'b1, 1'b0);
    chk("loss_locked", locked, 0);
    chk("loss_state", state, 0);
    chk("loss_pulse", err_pulse, 1);
    chk("loss_cnt", err_cnt, 8);
    lock_clean("relock_bits");
    chk("relock_cnt", err_cnt, 8);

    step(1'b0, 1'b0, 1'b0);
    #2;
    rst_n = 1'b0;
    #1;
    chk("arst_locked", locked, 0);
    chk("arst_err_cnt", err_cnt, 0);
    chk("arst_state", state, 0);
    chk("arst_pulse", err_pulse, 0);
    model_reset();
    repeat (2) @(negedge clk);
    rst_n = 1'b1;

    vcnt = 0;
    for (int k = 0; k < 200; k++) begin
      if (k % 2 == 0) begin
        send(1'b0, 1'b0);
        vcnt++;
      end else begin
        step(1'b0, 1'($urandom_range(1)), 1'b0);
      end
      if (locked === 1'b1) break;
    end
    chk("gap_lock_bits", vcnt, 23);

    send(1'b1, 1'b1);
    chk("clr_err_pulse", err_pulse, 1);
    chk("clr_err_cnt", err_cnt, 0);

    for (int w = 0; w < 5; w++) begin
      for (int k = 0; k < 4; k++) send(1'b1, 1'b0);
      for (int k = 0; k < 60; k++) send(1'b0, 1'b0);
    end
    chk("sat_cnt", s_err_cnt, 15);
    chk("sat_main_cnt", err_cnt, 20);
    chk("sat_locked", s_locked, 1);

    cmp_en = 1'b0;
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/prbs_lfsr_checker.md
Name: prbs_lfsr_checker

Overview:
- Receive-side counterpart of the team's serial LFSR randomizer.
- Consumes one serial bit per qualified cycle and self-synchronises a local Fibonacci LFSR from the incoming stream.
- Once locked, free-runs the LFSR, flags every bit that disagrees with the prediction and keeps a saturating error count.
- Sits at the receive end of the link under test as the BER/lock monitor.

Parameters:
- WIDTH, 7: LFSR length in bits (>=3).
- POLY, 7'h60: tap mask; bit i set means state[i] feeds the feedback XOR (default x^7+x^6+1).
- LOCK_CNT, 16: consecutive matching bits in HUNT required to declare lock (>WIDTH).
- WINDOW, 64: bits per loss-of-lock observation window.
- LOSS_THRESH, 8: errors within one window that force loss of lock.
- ERR_W, 16: width of err_cnt.

Ports:
- clk  in  1  rising-edge clock.
- rst_n  in  1  asynchronous active-low reset.
- bit_vld  in  1  rx_bit is valid this cycle; all state advances only when high.
- rx_bit  in  1  received serial bit.
- clr_cnt  in  1  synchronous clear of err_cnt.
- locked  out  1  high while in LOCKED.
- err_pulse  out  1  one-cycle pulse per mismatched bit while LOCKED.
- err_cnt  out  ERR_W  saturating error count.
- state  out  2  FILL=0, HUNT=1, LOCKED=2.

Behaviour:
- Interface: one clock (clk); reset is asynchronous and active-low (rst_n). Reset drives state=FILL, LFSR=0, all counters=0, locked=0, err_pulse=0, err_cnt=0. Reset asserted mid-operation aborts immediately to these values.
- Predicted bit p = XOR over i of (lfsr[i] & POLY[i]), combinational from the current register.
- Shift on each accepted bit: lfsr <= {lfsr[WIDTH-2:0], d}. In FILL/HUNT, d=rx_bit. In LOCKED, d=p (free-run).
- All outputs are registered and reflect bit n at the clock edge that accepts it, i.e. visible the cycle after bit_vld.
- With bit_vld=0: nothing changes and err_pulse=0.
- FILL:
  - Shift WIDTH bits with no comparison; fill_cnt counts 0..WIDTH-1.
  - On the WIDTH-th bit, go to HUNT with match_cnt=0.
- HUNT:
  - Compare rx_bit to p.
  - Match: match_cnt++.
  - Mismatch: match_cnt=0 and stay in HUNT (LFSR still loads rx_bit, so it resyncs).
  - When the LOCK_CNT-th consecutive match is accepted: go to LOCKED, locked=1 on that edge, win_cnt=0, win_err=0.
- LOCKED:
  - Compare rx_bit to p.
  - Mismatch: err_pulse=1 and err_cnt+1, saturating at all-ones. win_err++.
  - win_cnt counts accepted bits; after the WINDOW-th bit, win_cnt=0 and win_err=0.
  - When win_err reaches LOSS_THRESH (counting the current bit): go to FILL, locked=0, fill_cnt=0. This takes priority over window rollover on the same bit.
  - The error bit that causes loss still pulses err_pulse and counts.
- Errors are never counted in FILL/HUNT.
- clr_cnt: err_cnt <= 0. If clr_cnt coincides with an error, err_cnt=0 (clear wins) but err_pulse still asserts. clr_cnt does not affect lock state.
- Counter widths: $clog2 of the respective maxima plus 1; no wrap inside a phase.

Optional Feature:
- PRBS_CHK_INV_EN defined:
  - Adds input rx_inv (1 bit).
  - When rx_inv is high, rx_bit is inverted before all processing, for polarity-swapped links.
  - rx_inv is sampled only on bit_vld cycles.
- Not defined: port absent; rx_bit is used as-is.

Decomposition:
- Shared package prbs_pkg:
  - state encoding constants FILL/HUNT/LOCKED;
  - default polynomial constants (PRBS7 7'h60, PRBS4 4'h9);
  - default LOCK_CNT/WINDOW/LOSS_THRESH.
- One sub-module, prbs_lfsr_core: holds the WIDTH-bit register, computes p, and shifts on an enable with a selectable load bit.
- FSM and counters live in prbs_lfsr_checker.

Test Plan:
- Clean lock: PRBS7 stream from seed 7'h7F, bit_vld=1 continuously, then locked rises after exactly 7+16=23 accepted bits. err_cnt stays 0 over 500 further bits.
- Single error: after lock, flip one bit. Expect exactly one err_pulse the cycle after that bit and err_cnt=1. LFSR is not disturbed and there are no further pulses.
- Loss of lock: after lock, flip 8 bits inside one 64-bit window, then locked falls on the 8th error edge and state=FILL. Clean data then relocks after 23 bits with err_cnt=8.
- Window rollover: 7 errors in window 1, then 7 in window 2, then locked stays 1 and err_cnt=14.
- Gapped valid / clear: bit_vld toggling 1-0-1, then lock takes 23 valid bits regardless of gaps. clr_cnt coincident with an error gives err_cnt=0 with err_pulse=1.
- Reset and saturation: rst_n low mid-LOCKED gives all outputs 0 asynchronously. With ERR_W=4 and 20 errors spread across windows, err_cnt saturates at 4'hF.
